dmem_lsu: RTL

- Parametrised byte-addressable data memory with load/store unit front end. Successor to the fixed 256-word data memory.
- Sits between the MEM stage and on-chip RAM, with a valid/ready request and a fixed-latency response pipeline.
- Adds configurable width, depth and read latency, size/sign handling, misalignment and out-of-range detection, and an optional post-reset zero-scrub.

---
 rtl/dmem_lsu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with a load/store front end: size/sign handling,
// fault detection, fixed-latency response pipeline and optional post-reset zero-scrub.
module dmem_lsu #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  rsp_oob,
  output logic                  scrub_busy
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam int unsigned AW  = $clog2(DEPTH);

  typedef enum logic {SCRUB, RUN} state_t;

  state_t                r_state;
  logic [AW-1:0]         r_scrub_idx;
  logic                  r_ready;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];
  logic                  r_pm [READ_LATENCY];
  logic                  r_po [READ_LATENCY];

  logic [OFS-1:0]        w_lane;
  logic [AW-1:0]         w_idx;
  logic                  w_accept;
  logic                  w_mis;
  logic                  w_oob;
  logic                  w_sign;
  int unsigned           w_nbytes;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_wshift;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [NB-1:0]         w_be;

  assign w_lane   = req_addr[OFS-1:0];
  assign w_idx    = req_addr[OFS +: AW];
  assign w_accept = req_valid && r_ready;

  always_comb begin
    w_nbytes = 32'd1 << req_size;
    w_mis    = ((req_size == 2'd3) && (NB == 32'd4)) || ((32'(w_lane) & (w_nbytes - 32'd1)) != 32'd0);
    w_oob    = !w_mis && ((req_addr >> OFS) >= DEPTH);
    w_shift  = r_mem[w_idx] >> {w_lane, 3'b000};
    w_wshift = req_wdata << {w_lane, 3'b000};
    w_sign   = 1'b0;
    w_ext    = '0;
    w_be     = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b + 32'd1 == w_nbytes) w_sign = w_shift[8*b+7];
    end
    // bytes above the access size are filled with the sign (or zero)
    for (int unsigned b = 0; b < NB; b++) begin
      w_ext[8*b +: 8] = (b < w_nbytes) ? w_shift[8*b +: 8] : {8{w_sign & ~req_unsigned}};
      w_be[b]         = (b >= 32'(w_lane)) && (b < 32'(w_lane) + w_nbytes);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= (INIT_ZERO != 0) ? SCRUB : RUN;
      r_scrub_idx <= '0;
      r_ready     <= (INIT_ZERO == 0);
      r_busy      <= (INIT_ZERO != 0);
    end else begin
      case (r_state)
        SCRUB: begin
          r_scrub_idx <= r_scrub_idx + AW'(1);
          if (r_scrub_idx == AW'(DEPTH - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // array has no reset; the scrub pass is what clears it
  always_ff @(posedge clk) begin
    if (r_state == SCRUB) begin
      r_mem[r_scrub_idx] <= '0;
    end else if (w_accept && req_we && !w_mis && !w_oob) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pm[i] <= 1'b0;
        r_po[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= (w_accept && !req_we && !w_mis && !w_oob) ? w_ext : '0;
      r_pm[0] <= w_accept && w_mis;
      r_po[0] <= w_accept && w_oob;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pm[i] <= r_pm[i-1];
        r_po[i] <= r_po[i-1];
      end
    end
  end

  assign req_ready      = r_ready;
  assign scrub_busy     = r_busy;
  assign rsp_valid      = r_pv[READ_LATENCY-1];
  assign rsp_rdata      = r_pd[READ_LATENCY-1];
  assign rsp_misaligned = r_pm[READ_LATENCY-1];
  assign rsp_oob        = r_po[READ_LATENCY-1];

endmodule
